sha256_block_engine: RTL and testbench

SHA256_BLOCK_ENGINE -- requirements
Module: sha256_block_engine

---
 rtl/sha256_block_engine.sv | 164 ++++++++++++++++
 tb/tb_sha256_block_engine.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_engine.sv
// SHA-256 compression engine: one 512-bit block per transfer, UNROLL rounds per clock,
// message schedule generated in a 16-word sliding window, chain value kept across blocks.
module sha256_block_engine #(
    parameter int UNROLL = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_first,
    input  logic         in_last,
    input  logic [511:0] chunk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] digest,
    output logic         busy
);
    localparam int CYCLES = 64 / UNROLL;

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, HOLD} state_t;

    state_t         state_q, state_d;
    logic [511:0]   blk_q;
    logic           first_q, last_q, out_valid_q;
    logic [5:0]     cnt_q;
    logic [31:0]    wv_q [8];
    logic [31:0]    w_q [16];
    logic [31:0]    chain_q [8];
    logic [255:0]   digest_q;

    logic [31:0]    rv [8];
    logic [31:0]    rw [16];
    logic [31:0]    t1, t2, nw;
    logic [5:0]     rt;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = LOAD;
            LOAD:    state_d = ROUND;
            ROUND:   if (cnt_q == 6'(CYCLES - 1)) state_d = FINAL;
            FINAL:   state_d = last_q ? HOLD : IDLE;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // UNROLL rounds chained combinationally; w[0] is always W(t) of the round being computed
    always_comb begin
        rv = wv_q;
        rw = w_q;
        t1 = '0;
        t2 = '0;
        nw = '0;
        rt = '0;
        for (int j = 0; j < UNROLL; j++) begin
            rt = 6'(int'(cnt_q) * UNROLL + j);
            t1 = rv[7] + bsig1(rv[4]) + ((rv[4] & rv[5]) ^ (~rv[4] & rv[6])) + K[rt] + rw[0];
            t2 = bsig0(rv[0]) + ((rv[0] & rv[1]) ^ (rv[0] & rv[2]) ^ (rv[1] & rv[2]));
            nw = ssig1(rw[14]) + rw[9] + ssig0(rw[1]) + rw[0];
            rv[7] = rv[6];
            rv[6] = rv[5];
            rv[5] = rv[4];
            rv[4] = rv[3] + t1;
            rv[3] = rv[2];
            rv[2] = rv[1];
            rv[1] = rv[0];
            rv[0] = t1 + t2;
            for (int i = 0; i < 15; i++) rw[i] = rw[i + 1];
            rw[15] = nw;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            blk_q       <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            digest_q    <= '0;
            for (int i = 0; i < 8; i++) begin
                chain_q[i] <= IV[i];
                wv_q[i]    <= '0;
            end
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    blk_q   <= chunk;
                    first_q <= in_first;
                    last_q  <= in_last;
                end
                // chain_q takes the selected base so FINAL can always add chain_q
                LOAD: begin
                    for (int i = 0; i < 8; i++) begin
                        wv_q[i]    <= first_q ? IV[i] : chain_q[i];
                        chain_q[i] <= first_q ? IV[i] : chain_q[i];
                    end
                    for (int i = 0; i < 16; i++) w_q[i] <= blk_q[511 - 32 * i -: 32];
                    cnt_q <= '0;
                end
                ROUND: begin
                    wv_q  <= rv;
                    w_q   <= rw;
                    cnt_q <= cnt_q + 6'd1;
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) begin
                        chain_q[i] <= chain_q[i] + wv_q[i];
                        if (last_q) digest_q[255 - 32 * i -: 32] <= chain_q[i] + wv_q[i];
                    end
                    if (last_q) out_valid_q <= 1'b1;
                end
                HOLD: if (out_ready) out_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign digest    = digest_q;
endmodule

// File: tb/tb_sha256_block_engine.sv
// Directed bench: known SHA-256 vectors over four engines (UNROLL 1/2/4/8) sharing one stimulus.
module tb_sha256_block_engine;
    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_first = 1'b0;
    logic         in_last = 1'b0;
    logic         out_ready = 1'b1;
    logic [511:0] chunk = '0;

    logic         ir1, ir2, ir4, ir8, ov1, ov2, ov4, ov8, bs1, bs2, bs4, bs8;
    logic [255:0] dg1, dg2, dg4, dg8;

    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [511:0] ABC   = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] TWO1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO2  = {480'h0, 32'h000001c0};
    localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMP = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    typedef struct {
        logic [511:0] blk;
        logic         first;
        logic         last;
        logic [255:0] dig;
        int           lat;
    } vec_t;

    vec_t vecs [4];

    always #5 clock = ~clock;

    sha256_block_engine #(.UNROLL(1)) u1 (.clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir1),
        .in_first(in_first), .in_last(in_last), .chunk(chunk), .out_valid(ov1), .out_ready(out_ready),
        .digest(dg1), .busy(bs1));
    sha256_block_engine #(.UNROLL(2)) u2 (.clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir2),
        .in_first(in_first), .in_last(in_last), .chunk(chunk), .out_valid(ov2), .out_ready(out_ready),
        .digest(dg2), .busy(bs2));
    sha256_block_engine #(.UNROLL(4)) u4 (.clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir4),
        .in_first(in_first), .in_last(in_last), .chunk(chunk), .out_valid(ov4), .out_ready(out_ready),
        .digest(dg4), .busy(bs4));
    sha256_block_engine #(.UNROLL(8)) u8 (.clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir8),
        .in_first(in_first), .in_last(in_last), .chunk(chunk), .out_valid(ov8), .out_ready(out_ready),
        .digest(dg8), .busy(bs8));

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
        else pass_cnt++;
    endtask

    // Called at posedge+1 with the engines idle; returns one cycle after the accepting edge.
    task automatic send(input logic [511:0] c, input logic f, input logic l);
        in_valid = 1'b1;
        chunk    = c;
        in_first = f;
        in_last  = l;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clock); #1;
            if (ov1) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat, l1, l2, l4, l8;
        logic seen_ov;
        logic ir_65, ir_66;

        vecs[0] = '{blk: ABC,   first: 1'b1, last: 1'b1, dig: D_ABC, lat: 66};
        vecs[1] = '{blk: EMPTY, first: 1'b1, last: 1'b1, dig: D_EMP, lat: 66};
        vecs[2] = '{blk: TWO1,  first: 1'b1, last: 1'b0, dig: '0,    lat: 66};
        vecs[3] = '{blk: TWO2,  first: 1'b0, last: 1'b1, dig: D_TWO, lat: 66};

        repeat (3) @(posedge clock);
        #1;
        chk("reset_in_ready", 256'(ir1), 256'(1'b1));
        chk("reset_out_valid", 256'(ov1), 256'(1'b0));
        chk("reset_busy", 256'(bs1), 256'(1'b0));
        chk("reset_digest", dg1, 256'h0);
        reset = 1'b1;
        @(posedge clock); #1;

        for (int v = 0; v < 4; v++) begin
            send(vecs[v].blk, vecs[v].first, vecs[v].last);
            if (vecs[v].last) begin
                wait_out(lat);
                chk($sformatf("vec%0d_latency", v), 256'(lat), 256'(vecs[v].lat));
                chk($sformatf("vec%0d_digest", v), dg1, vecs[v].dig);
                @(posedge clock); #1;
                chk($sformatf("vec%0d_release", v), 256'(ov1), 256'(1'b0));
            end else begin
                seen_ov = 1'b0;
                ir_65 = 1'b1;
                ir_66 = 1'b0;
                for (int k = 1; k <= vecs[v].lat; k++) begin
                    @(posedge clock); #1;
                    if (ov1) seen_ov = 1'b1;
                    if (k == vecs[v].lat - 1) ir_65 = ir1;
                    if (k == vecs[v].lat) ir_66 = ir1;
                end
                chk($sformatf("vec%0d_no_out_valid", v), 256'(seen_ov), 256'(1'b0));
                chk($sformatf("vec%0d_ready_early", v), 256'(ir_65), 256'(1'b0));
                chk($sformatf("vec%0d_ready_back", v), 256'(ir_66), 256'(1'b1));
            end
        end

        // all four widths on "abc" with backpressure and junk offered while busy
        out_ready = 1'b0;
        send(ABC, 1'b1, 1'b1);
        l1 = -1; l2 = -1; l4 = -1; l8 = -1;
        for (int k = 1; k <= 71; k++) begin
            in_valid = (k <= 20);
            chunk    = {16{32'hdeadbeef}};
            in_first = 1'b1;
            @(posedge clock); #1;
            if (ov1 && l1 < 0) l1 = k;
            if (ov2 && l2 < 0) l2 = k;
            if (ov4 && l4 < 0) l4 = k;
            if (ov8 && l8 < 0) l8 = k;
        end
        in_valid = 1'b0;
        chk("u1_latency", 256'(l1), 256'(66));
        chk("u2_latency", 256'(l2), 256'(34));
        chk("u4_latency", 256'(l4), 256'(18));
        chk("u8_latency", 256'(l8), 256'(10));
        chk("u1_digest", dg1, D_ABC);
        chk("u2_digest", dg2, D_ABC);
        chk("u4_digest", dg4, D_ABC);
        chk("u8_digest", dg8, D_ABC);
        chk("hold_out_valid", 256'(ov1), 256'(1'b1));
        chk("hold_in_ready", 256'(ir1), 256'(1'b0));
        chk("hold_busy", 256'(bs1), 256'(1'b1));
        out_ready = 1'b1;
        @(posedge clock); #1;
        chk("release_out_valid", 256'(ov1), 256'(1'b0));
        chk("release_in_ready", 256'(ir1), 256'(1'b1));
        chk("digest_kept", dg1, D_ABC);

        // abort block 1 of the two-block message mid-round, then chain "abc" with first=0
        send(TWO1, 1'b1, 1'b0);
        repeat (32) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        chk("abort_busy", 256'(bs1), 256'(1'b0));
        chk("abort_out_valid", 256'(ov1), 256'(1'b0));
        chk("abort_digest", dg1, 256'h0);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("abort_in_ready", 256'(ir1), 256'(1'b1));
        send(ABC, 1'b0, 1'b1);
        wait_out(lat);
        chk("iv_chain_latency", 256'(lat), 256'(66));
        chk("iv_chain_digest", dg1, D_ABC);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
